// File: rtl/data_or2_arbiter_if.sv
// Requester-side handshakes plus the hookup to the shared dataOr2 unit.
// The slave modport is the arbiter's view.
interface data_or2_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 2,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       reqValid;
  logic [NREQ*WIDTH-1:0] reqA;
  logic [NREQ*WIDTH-1:0] reqB;
  logic [NREQ-1:0]       reqReady;
  logic [WIDTH-1:0]      orIn1;
  logic [WIDTH-1:0]      orIn2;
  logic [WIDTH-1:0]      orOut;
  logic [NREQ-1:0]       respValid;
  logic [WIDTH-1:0]      respData;
  logic [NREQ-1:0]       respReady;
  logic [IDW-1:0]        grantId;
  logic                  busy;

  modport slave (
    input  reqValid, reqA, reqB, orOut, respReady,
    output reqReady, orIn1, orIn2, respValid, respData, grantId, busy
  );

  modport master (
    output reqValid, reqA, reqB, orOut, respReady,
    input  reqReady, orIn1, orIn2, respValid, respData, grantId, busy
  );
endinterface

// File: rtl/data_or2_arbiter.sv
// Round-robin scheduler sharing one external dataOr2 unit among NREQ requesters.
// One transaction at a time: accept (IDLE), capture (ISSUE), hand back (RESP).
module data_or2_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 2,
  parameter int IDW   = 2
) (
  input logic               clk,
  input logic               rst,
  data_or2_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [IDW-1:0]   last_grant_r;
  logic [IDW-1:0]   grant_r;
  logic [IDW-1:0]   win_s;
  logic             win_found_s;
  logic             accept_s;
  logic             capture_s;
  logic             release_s;
  logic [NREQ-1:0]  req_ready_s;
  logic [NREQ-1:0]  resp_valid_r;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [WIDTH-1:0] resp_data_r;

  // First set bit of valid searching upward from last+1 with wrap; MSB flags a hit.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                           input logic [IDW-1:0]  last);
    logic [IDW:0] pick;
    int           idx;
    pick = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!pick[IDW] && valid[idx]) begin
        pick = {1'b1, IDW'(idx)};
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  // Next-state decode and the single-cycle accept pulse.
  always_comb begin
    {win_found_s, win_s} = rr_pick(bus.reqValid, last_grant_r);
    state_s     = state_r;
    req_ready_s = '0;
    accept_s    = 1'b0;
    capture_s   = 1'b0;
    release_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (win_found_s && !rst) begin
          accept_s           = 1'b1;
          req_ready_s[win_s] = 1'b1;
          state_s            = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        capture_s = 1'b1;
        state_s   = ST_RESP;
      end
      ST_RESP: begin
        // Only the owner's respReady can release the response.
        if (bus.respReady[grant_r]) begin
          release_s = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, operand, grant and response registers; reset wins over any transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      last_grant_r <= IDW'(NREQ - 1);
      grant_r      <= '0;
      op_a_r       <= '0;
      op_b_r       <= '0;
      resp_data_r  <= '0;
      resp_valid_r <= '0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        op_a_r  <= bus.reqA[win_s*WIDTH +: WIDTH];
        op_b_r  <= bus.reqB[win_s*WIDTH +: WIDTH];
        grant_r <= win_s;
      end
      if (capture_s) begin
        resp_data_r  <= bus.orOut;
        resp_valid_r <= {{(NREQ-1){1'b0}}, 1'b1} << grant_r;
      end
      if (release_s) begin
        resp_valid_r <= '0;
        last_grant_r <= grant_r;
      end
    end
  end

  assign bus.reqReady  = req_ready_s;
  assign bus.orIn1     = op_a_r;
  assign bus.orIn2     = op_b_r;
  assign bus.respValid = resp_valid_r;
  assign bus.respData  = resp_data_r;
  assign bus.grantId   = grant_r;
  assign bus.busy      = (state_r != ST_IDLE);
endmodule

// File: tb/tb_data_or2_arbiter.sv
// Randomized bench for data_or2_arbiter: per-requester request queues drive the DUT,
// a transaction-level model predicts grants and results, a scoreboard checks responses.
module tb_data_or2_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 2;
  localparam int IDW   = 2;
  localparam int QD    = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_or2_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();
  // Behaves as the external dataOr2 instance.
  assign bus.orOut = bus.orIn1 | bus.orIn2;

  data_or2_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t             exp_q[$];
  logic             owner_valid = 1'b0;
  logic [IDW-1:0]   owner       = '0;
  logic [IDW-1:0]   last        = IDW'(NREQ - 1);
  logic [WIDTH-1:0] cur_a       = '0;
  logic [WIDTH-1:0] cur_b       = '0;
  int               acc_cyc     = 0;
  int               cyc         = 0;
  logic             rst_q       = 1'b0;

  task automatic zero_checks();
    chk("rst_respValid", 32'(bus.respValid), 32'd0);
    chk("rst_respData",  32'(bus.respData),  32'd0);
    chk("rst_orIn1",     32'(bus.orIn1),     32'd0);
    chk("rst_orIn2",     32'(bus.orIn2),     32'd0);
    chk("rst_grantId",   32'(bus.grantId),   32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
  endtask

  initial begin : monitor
    logic [NREQ-1:0] exp_rr;
    logic [NREQ-1:0] exp_rv;
    logic            found;
    int              w;
    exp_t            e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_q) zero_checks();
      if (rst) begin
        chk("reqReady_in_reset", 32'(bus.reqReady), 32'd0);
        owner_valid = 1'b0;
        last        = IDW'(NREQ - 1);
        exp_q.delete();
      end else begin
        exp_rr = '0;
        if (!owner_valid && bus.reqValid != '0) begin
          found = 1'b0;
          w     = 0;
          for (int k = 1; k <= NREQ; k++) begin
            if (!found && bus.reqValid[(int'(last) + k) % NREQ]) begin
              found = 1'b1;
              w     = (int'(last) + k) % NREQ;
            end
          end
          exp_rr      = oh(w);
          owner_valid = 1'b1;
          owner       = IDW'(w);
          acc_cyc     = cyc;
          cur_a       = bus.reqA[w*WIDTH +: WIDTH];
          cur_b       = bus.reqB[w*WIDTH +: WIDTH];
          exp_q.push_back('{id: IDW'(w), data: cur_a | cur_b});
        end
        chk("reqReady", 32'(bus.reqReady), 32'(exp_rr));
        if (owner_valid && cyc > acc_cyc) begin
          chk("orIn1",   32'(bus.orIn1),   32'(cur_a));
          chk("orIn2",   32'(bus.orIn2),   32'(cur_b));
          chk("grantId", 32'(bus.grantId), 32'(owner));
          chk("busy",    32'(bus.busy),    32'd1);
        end else begin
          chk("busy_idle", 32'(bus.busy), 32'd0);
        end
        exp_rv = (owner_valid && cyc >= acc_cyc + 2) ? oh(int'(owner)) : '0;
        chk("respValid", 32'(bus.respValid), 32'(exp_rv));
        if (exp_rv != '0) chk("respData_hold", 32'(bus.respData), 32'(cur_a | cur_b));
        // Scoreboard: pop whenever the DUT completes a response handshake.
        if ((bus.respValid & bus.respReady) != '0) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL resp_unexpected: got respValid=%b want no response", bus.respValid);
          end else begin
            e = exp_q.pop_front();
            chk("resp_id",   32'(bus.respValid), 32'(oh(int'(e.id))));
            chk("resp_data", 32'(bus.respData),  32'(e.data));
          end
        end
        if (exp_rv != '0 && bus.respReady[owner]) begin
          owner_valid = 1'b0;
          last        = owner;
        end
      end
      rst_q = rst;
    end
  end

  // ---------------- stimulus ----------------
  logic [WIDTH-1:0] qa [NREQ][QD];
  logic [WIDTH-1:0] qb [NREQ][QD];
  int               qh [NREQ];
  int               qt [NREQ];
  int               resp_mode = 0;

  task automatic push(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    qa[id][qt[id] % QD] = a;
    qb[id][qt[id] % QD] = b;
    qt[id]++;
  endtask

  task automatic present();
    for (int i = 0; i < NREQ; i++) begin
      if (qt[i] != qh[i]) begin
        bus.reqValid[i]              = 1'b1;
        bus.reqA[i*WIDTH +: WIDTH]   = qa[i][qh[i] % QD];
        bus.reqB[i*WIDTH +: WIDTH]   = qb[i][qh[i] % QD];
      end else begin
        bus.reqValid[i]              = 1'b0;
        bus.reqA[i*WIDTH +: WIDTH]   = WIDTH'($urandom);
        bus.reqB[i*WIDTH +: WIDTH]   = WIDTH'($urandom);
      end
    end
    case (resp_mode)
      0:       bus.respReady = '1;
      1:       bus.respReady = NREQ'($urandom);
      2:       bus.respReady = '0;
      default: bus.respReady = ~oh(int'(owner));
    endcase
  endtask

  task automatic tick();
    logic [NREQ-1:0] seen;
    @(negedge clk);
    seen = bus.reqReady;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (seen[i] && qt[i] != qh[i]) qh[i]++;
    end
    present();
  endtask

  function automatic logic all_idle();
    logic idle;
    idle = !owner_valid && exp_q.size() == 0;
    for (int i = 0; i < NREQ; i++) begin
      if (qt[i] != qh[i]) idle = 1'b0;
    end
    return idle;
  endfunction

  task automatic drain(input int budget);
    for (int n = 0; n < budget && !all_idle(); n++) tick();
    chk("drain_done", 32'(all_idle()), 32'd1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    present();
    repeat (n) tick();
    rst = 1'b0;
    present();
  endtask

  initial begin : stimulus
    for (int i = 0; i < NREQ; i++) begin
      qh[i] = 0;
      qt[i] = 0;
    end
    bus.reqValid  = '0;
    bus.reqA      = '0;
    bus.reqB      = '0;
    bus.respReady = '0;

    // Reset, then a single request from requester 0.
    do_reset(2);
    push(0, 2'b01, 2'b10);
    present();
    drain(50);

    // Continuous requests from all: grants 0,1,2,3 in turn, A=i, B=0.
    do_reset(2);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NREQ; i++) push(i, WIDTH'(i), 2'b00);
    end
    present();
    drain(200);

    // Wrap and skip: lastGrant=2, then 0 and 2 pending.
    do_reset(2);
    push(2, 2'b11, 2'b00);
    present();
    drain(50);
    push(0, 2'b01, 2'b00);
    push(2, 2'b10, 2'b01);
    present();
    drain(50);

    // Backpressure: owner withholds respReady while non-owners assert theirs.
    resp_mode = 3;
    push(1, 2'b10, 2'b00);
    push(3, 2'b01, 2'b01);
    push(0, 2'b00, 2'b11);
    present();
    repeat (8) tick();
    resp_mode = 0;
    drain(100);

    // Reset while a response is pending; priority restarts at 0.
    resp_mode = 2;
    push(2, 2'b01, 2'b10);
    present();
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    resp_mode = 0;
    for (int i = 0; i < NREQ; i++) push(i, WIDTH'($urandom), WIDTH'($urandom));
    present();
    drain(100);

    // Every operand combination, random requesters and random respReady.
    resp_mode = 1;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) push($urandom_range(0, NREQ - 1), WIDTH'(a), WIDTH'(b));
    end
    present();
    drain(1000);

    // Random traffic.
    repeat (200) begin
      push($urandom_range(0, NREQ - 1), WIDTH'($urandom), WIDTH'($urandom));
      if ($urandom_range(0, 1) == 1) tick();
    end
    present();
    drain(4000);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end
endmodule

// File: doc/data_or2_arbiter.md
# data_or2_arbiter

Round-robin scheduler that shares one `dataOr2` unit among `NREQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The arbiter accepts one request at a time, drives the shared OR datapath, registers its result and returns it to the winning requester with a response handshake. It sits between the requester-side logic and a single external `dataOr2` instance.

## Interface
- `NREQ`, 4: number of requesters, range 2..8.
- `WIDTH`, 2: operand and result width; must match the attached `dataOr2`.
- `IDW`, 2: grant-index width, equal to ceil(log2(NREQ)).

- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `reqValid` input NREQ: bit i set means requester i has an operand pair pending.
- `reqA` input NREQ*WIDTH: operand 1 of requester i, in bits [i*WIDTH +: WIDTH].
- `reqB` input NREQ*WIDTH: operand 2 of requester i, same packing as `reqA`.
- `reqReady` output NREQ: one-hot, one-cycle accept pulse to the winning requester.
- `orIn1` output WIDTH: drives `dataIn1` of the shared `dataOr2`.
- `orIn2` output WIDTH: drives `dataIn2` of the shared `dataOr2`.
- `orOut` input WIDTH: from `dataOut` of the shared `dataOr2` (combinational).
- `respValid` output NREQ: one-hot, result available for requester i.
- `respData` output WIDTH: registered OR result.
- `respReady` input NREQ: bit i set means requester i consumes its response.
- `grantId` output IDW: index of the current or last owner.
- `busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- The FSM has three states: IDLE, ISSUE and RESP.
- **IDLE**
  - If any `reqValid` bit is set, pick winner w by round-robin: search starts at `lastGrant+1` mod NREQ and takes the first set bit.
  - Assert `reqReady[w]` for this cycle only.
  - Latch `reqA`/`reqB` slice w into operand registers that drive `orIn1`/`orIn2`.
  - Set `grantId=w` and go to ISSUE.
  - If no `reqValid` bit is set, stay in IDLE with all outputs unchanged.
- **ISSUE**
  - Capture `orOut` into `respData`, set `respValid[grantId]` and go to RESP.
- **RESP**
  - Hold `respValid[grantId]` and `respData` stable.
  - When `respReady[grantId]` is high, clear `respValid`, set `lastGrant=grantId` and go to IDLE.
  - `respReady` bits of non-owners are ignored.
- **Requester rules**
  - A requester must keep `reqValid` and its operands stable until it sees `reqReady`.
  - A request whose `reqValid` is dropped before acceptance is never served.
- **Datapath**
  - `orIn1`/`orIn2` change only on acceptance and stay stable through ISSUE and RESP.
  - `respData` equals operand1 | operand2 bitwise, with no width extension.
- **Reset**
  - Outputs: `reqReady=0`, `respValid=0`, `respData=0`, `orIn1=orIn2=0`, `grantId=0`, `busy=0`.
  - Internal: state IDLE, `lastGrant=NREQ-1`, so requester 0 has first priority.
- **Reset mid-operation** aborts the in-flight transaction. No response is issued, and the requester must re-request.

## Timing
- Acceptance in cycle T (IDLE with `reqValid` set and `reqReady` pulsed).
- Result captured at the end of T+1; `respValid` high from T+2.
- Minimum request-to-response latency is 2 cycles.
- Maximum throughput is one transaction per 3 cycles, when `respReady` is already high at T+2.
- `reqReady` is never asserted outside IDLE. New requests arriving during ISSUE or RESP wait.
- **Simultaneous requests:** exactly one winner per acceptance. Fairness bound: a continuously valid requester is served within NREQ transactions.
- **Wrap-around:** the search wraps from NREQ-1 back to 0.
- **Same-cycle events:** a `respReady` in the RESP cycle returns the FSM to IDLE on the next edge. A new acceptance can then occur in that IDLE cycle, with the pointer already updated.
- `rst` has priority over every transition in the same cycle.

## Test plan
- **Reset:** assert `rst` 2 cycles. All outputs are 0 and `busy=0`; `reqValid=0001`, A=2'b01, B=2'b10 then gives `reqReady=0001` in the first post-reset cycle and `respData=2'b11` with `respValid=0001` two cycles later.
- **Round-robin:** hold `reqValid=1111` with `respReady=1111`. Grants go in order 0,1,2,3,0, each 3 cycles apart; operands A=i, B=0 give `respData`=i for each grant.
- **Wrap and skip:** `lastGrant=2`, `reqValid=0101`. The grant goes to 0 (3 is skipped, then wrap); the next grant goes to 2.
- **Response backpressure:** hold `respReady[w]=0` for 5 cycles. `respValid` and `respData` stay stable and `reqReady` stays 0 for all other requesters; a `respReady` pulse leads to IDLE on the next edge.
- **Reset mid-operation:** assert `rst` during RESP. `respValid` is 0 on the next cycle and no response is delivered; priority restarts at requester 0.
- **Exhaustive datapath:** for every one of the 16 A/B combinations, `respData` equals A|B.
